axis_vid_out: RTL and testbench

AXIS_VID_OUT -- requirements
Module: axis_vid_out

---
 rtl/axis_vid_out.sv | 204 ++++++++++++++++++++
 tb/tb_axis_vid_out.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_vid_out.sv
// -----------------------------------------------------------------------------
// axis_vid_out
//
// Converts an AXI4-Stream pixel stream from a frame-buffer reader into a
// parallel video interface (data / hsync / vsync / de) for a DVI transmitter.
//
// A pair of free-running counters (hcnt, vcnt) generates the raster timing.
// A small lock FSM aligns the incoming stream to that raster:
//   HUNT : discard beats until a start-of-frame (tuser) beat is seen; the SOF
//          beat is held (not accepted).
//   WAIT : hold the SOF beat until the raster reaches its last cycle.
//   RUN  : consume exactly one beat per active pixel. A missing beat
//          (underflow) or a beat whose tuser/tlast disagrees with the raster
//          position drops back to HUNT. The raster itself never stops.
//
// Ports
//   clk            pixel clock (single clock domain)
//   resetn         asynchronous active-low reset
//   s_axis_tdata   24-bit pixel from the frame-buffer reader
//   s_axis_tvalid  pixel valid
//   s_axis_tready  pixel accept
//   s_axis_tuser   start of frame marker (first pixel of a frame)
//   s_axis_tlast   end of line marker (last pixel of a line)
//   vid_data       registered pixel, zero when no beat was accepted
//   vid_hsync      registered horizontal sync, active low
//   vid_vsync      registered vertical sync, active low
//   vid_de         registered data enable
//   locked         high while the FSM is in RUN
//   underflow      one-cycle pulse when RUN finds no pixel for an active slot
// -----------------------------------------------------------------------------
module axis_vid_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [23:0] vid_data,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic        locked,
    output logic        underflow
);

    // -------------------------------------------------------------------------
    // Raster geometry
    // -------------------------------------------------------------------------
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (HT > 1) ? $clog2(HT) : 1;
    localparam int VW = (VT > 1) ? $clog2(VT) : 1;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Lock FSM encoding
    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // -------------------------------------------------------------------------
    // Timing counters
    // -------------------------------------------------------------------------
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_end;
    logic          v_end;

    assign h_end = (int'(hcnt) == HT - 1);
    assign v_end = (int'(vcnt) == VT - 1);

    // NOTE: every clocked register uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_end) begin
            hcnt <= '0;
            vcnt <= v_end ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Raster decode (combinational, from current counter state)
    // -------------------------------------------------------------------------
    logic active;
    logic hs_i;
    logic vs_i;
    logic sof_pos;
    logic eol_pos;

    assign active  = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    assign hs_i    = !((int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END));
    assign vs_i    = !((int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END));
    assign sof_pos = (hcnt == '0) && (vcnt == '0);
    assign eol_pos = (int'(hcnt) == H_ACTIVE - 1);

    // -------------------------------------------------------------------------
    // Stream checks, meaningful only in RUN
    // -------------------------------------------------------------------------
    logic err_uf;   // active slot with no pixel available
    logic err_sof;  // tuser disagrees with raster origin
    logic err_eol;  // tlast disagrees with last active column
    logic err;

    assign err_uf  = active && !s_axis_tvalid;
    assign err_sof = active && s_axis_tvalid && (s_axis_tuser != sof_pos);
    assign err_eol = active && s_axis_tvalid && (s_axis_tlast != eol_pos);
    assign err     = err_uf || err_sof || err_eol;

    // -------------------------------------------------------------------------
    // Lock FSM
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ready_c;
    logic       ready_en;  // low during reset and for the first cycle after it
    logic       accept;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        unique case (state)
            ST_HUNT: begin
                // Non-SOF beats are accepted and dropped; an SOF beat is held.
                ready_c = !(s_axis_tvalid && s_axis_tuser);
                if (ready_en && s_axis_tvalid && s_axis_tuser) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (h_end && v_end) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Blanking stalls the source; any stream error refuses the beat.
                ready_c = active && !err;
                if (err) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    assign s_axis_tready = ready_en && ready_c;
    assign accept        = (state == ST_RUN) && s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_HUNT;
            ready_en <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            // Tracks the next state so that locked is high exactly in RUN.
            locked   <= (state_nxt == ST_RUN);
        end
    end

    // -------------------------------------------------------------------------
    // Output registers: one cycle behind the counters in every FSM state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vid_data  <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= 1'b1;
            vid_vsync <= 1'b1;
            underflow <= 1'b0;
        end else begin
            vid_data  <= accept ? s_axis_tdata : '0;
            vid_de    <= active;
            vid_hsync <= hs_i;
            vid_vsync <= vs_i;
            // Misalignment errors fall back to HUNT silently; only a missing
            // pixel is reported.
            underflow <= (state == ST_RUN) && err_uf;
        end
    end

endmodule

// File: tb/tb_axis_vid_out.sv
// -----------------------------------------------------------------------------
// tb_axis_vid_out
//
// Scoreboard bench for axis_vid_out on a reduced raster (16 x 8 total,
// 8 x 4 active, 128 cycles per frame). Stimulus pushes the expected vid_data
// for every vid_de cycle into a queue; the monitor pops one entry per vid_de
// cycle and also checks the sync/de timing against a raster model. A probe
// process checks locked/underflow/tready at hand-computed cycle numbers,
// where cyc counts rising edges since the last reset release.
// -----------------------------------------------------------------------------
module tb_axis_vid_out;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;  // 16
    localparam int VT  = VA + VFP + VS + VBP;  // 8
    localparam int NPIX = HA * VA;             // 32

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [23:0] vid_data;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_de;
    logic        locked;
    logic        underflow;

    axis_vid_out #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .vid_data      (vid_data),
        .vid_hsync     (vid_hsync),
        .vid_vsync     (vid_vsync),
        .vid_de        (vid_de),
        .locked        (locked),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          tmr_on = 1'b0;
    int          uf_count = 0;
    logic [23:0] exp_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Expected {de, hsync, vsync} for raster position t (cycles since release).
    function automatic logic [2:0] exp_timing(input int t);
        int h;
        int v;
        h = t % HT;
        v = (t / HT) % VT;
        exp_timing = {(h < HA) && (v < VA),
                      !((h >= HA + HFP) && (h < HA + HFP + HS)),
                      !((v >= VA + VFP) && (v < VA + VFP + VS))};
    endfunction

    function automatic bit model_active(input int c);
        return ((c % HT) < HA) && (((c / HT) % VT) < VA);
    endfunction

    function automatic logic [23:0] pix(input int i);
        logic [23:0] p;
        p[23:16] = 8'(i / HA);
        p[15:0]  = 16'(i % HA);
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor: raster timing model plus vid_data scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (resetn) begin
            if (tmr_on && cyc >= 1) begin
                check("timing_de_hs_vs", 32'({vid_de, vid_hsync, vid_vsync}), 32'(exp_timing(cyc - 1)));
            end
            if (vid_de) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vid_data_extra: got %06h required no pixel (cyc %0d)", vid_data, cyc);
                end else begin
                    check("vid_data", 32'(vid_data), 32'(exp_q.pop_front()));
                end
            end
            if (underflow) uf_count++;
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic at_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 5000);
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL at_cyc_%0d: reached %0d required %0d", n, cyc, n);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vid_data"},  32'(vid_data),      32'h0);
        check({tag, "_vid_de"},    32'(vid_de),        32'h0);
        check({tag, "_vid_hsync"}, 32'(vid_hsync),     32'h1);
        check({tag, "_vid_vsync"}, 32'(vid_vsync),     32'h1);
        check({tag, "_locked"},    32'(locked),        32'h0);
        check({tag, "_underflow"}, 32'(underflow),     32'h0);
        check({tag, "_tready"},    32'(s_axis_tready), 32'h0);
    endtask

    // First n pixels of a frame are expected on screen, the rest blank.
    task automatic push_frame(input int n);
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back((i < n) ? pix(i) : 24'h0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input bit bp);
        s_axis_tdata = d;
        s_axis_tuser = u;
        s_axis_tlast = l;
        for (int k = 0; k < 600; k++) begin
            if (bp && !model_active(cyc)) s_axis_tvalid = 1'($urandom_range(0, 1));
            else                          s_axis_tvalid = 1'b1;
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %06h not accepted within 600 cycles (cyc %0d)", d, cyc);
    endtask

    // gap: index preceded by one cycle of tvalid low; bad: index with tlast flipped.
    task automatic send_frame(input int gap, input int bad, input bit bp);
        for (int i = 0; i < NPIX; i++) begin
            if (i == gap) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(pix(i), i == 0, ((i % HA) == HA - 1) != (i == bad), bp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        // Power-on reset with a non-SOF beat offered: tready must stay low.
        resetn        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        resetn        = 1'b1;
        tmr_on        = 1'b1;

        // Free-running raster, no stream: two full frames plus lines 0-1 and
        // pixels 0-3 of line 2 of the third frame are seen before reset hits.
        push_frame(0);
        push_frame(0);
        for (int i = 0; i < 2 * HA + 4; i++) exp_q.push_back(24'h0);
        at_cyc(292);
        check("blank_locked", 32'(locked), 32'h0);
        check("blank_underflow_cnt", 32'(uf_count), 32'h0);
        @(posedge clk);
        #1;

        // Reset mid active line 2.
        tmr_on        = 1'b0;
        resetn        = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("mid");
        check("blank_drained", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        resetn        = 1'b1;
        tmr_on        = 1'b1;

        fork
            begin : source
                push_frame(0);                         // frame 0: HUNT/WAIT
                for (int j = 0; j < 3; j++) send_beat(24'hABCD00 + 24'(j), 1'b0, 1'b0, 1'b0);
                push_frame(NPIX);                      // frame 1: locked
                send_frame(-1, -1, 1'b0);
                push_frame(11);                        // frame 2: underflow at (1,3)
                send_frame(11, -1, 1'b0);
                push_frame(30);                        // frame 3: tlast on (3,6)
                send_frame(-1, 30, 1'b0);
                push_frame(NPIX);                      // frames 4-5: blanking jitter
                send_frame(-1, -1, 1'b1);
                push_frame(NPIX);
                send_frame(-1, -1, 1'b1);
                s_axis_tvalid = 1'b0;
            end
            begin : probes
                at_cyc(127);
                check("lock_before_boundary", 32'(locked), 32'h0);
                at_cyc(128);
                check("lock_at_boundary", 32'(locked), 32'h1);
                at_cyc(129);
                check("first_de", 32'(vid_de), 32'h1);
                check("first_pixel", 32'(vid_data), 32'h000000);
                at_cyc(150);
                check("line1_px5", 32'(vid_data), 32'h010005);
                at_cyc(275);
                check("uf_pre_locked", 32'(locked), 32'h1);
                check("uf_pre_pulse", 32'(underflow), 32'h0);
                at_cyc(276);
                check("uf_pulse", 32'(underflow), 32'h1);
                check("uf_locked_fall", 32'(locked), 32'h0);
                check("uf_pixel_zero", 32'(vid_data), 32'h0);
                at_cyc(277);
                check("uf_pulse_end", 32'(underflow), 32'h0);
                at_cyc(383);
                check("relock_before", 32'(locked), 32'h0);
                at_cyc(384);
                check("relock", 32'(locked), 32'h1);
                at_cyc(438);
                check("misalign_tready", 32'(s_axis_tready), 32'h0);
                check("misalign_pre_locked", 32'(locked), 32'h1);
                at_cyc(439);
                check("misalign_locked_fall", 32'(locked), 32'h0);
                check("misalign_no_underflow", 32'(underflow), 32'h0);
                at_cyc(511);
                check("bp_lock_before", 32'(locked), 32'h0);
                at_cyc(512);
                check("bp_lock", 32'(locked), 32'h1);
            end
        join

        at_cyc(760);
        check("final_drained", 32'(exp_q.size()), 32'h0);
        check("final_underflow_cnt", 32'(uf_count), 32'h1);
        check("final_locked", 32'(locked), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
